window_watchdog: RTL and testbench

Window watchdog timer that supervises a periodic heartbeat (KICK) from the monitored logic and drives the WDFAIL level consumed by the downstream failure-persistence counter/reset generator. A kick restarts the timeout only if it arrives inside the legal window. A late kick (timeout) or an early kick (before the window opens) raises WDFAIL. WDFAIL stays high until a kick is seen, so downstream logic can measure fail duration.

---
 rtl/window_watchdog_pkg.sv | 22 ++
 rtl/edge_rise.sv | 28 ++
 rtl/window_watchdog.sv | 142 ++++++++++++++
 tb/tb_window_watchdog.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_watchdog_pkg.sv
// ---------------------------------------------------------------------------
// window_watchdog_pkg : state encodings and defaults shared with fail counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package window_watchdog_pkg;

  localparam int WD_CNT_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLOSED = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;
  localparam logic [1:0] ST_FAIL   = 2'd3;

  function automatic logic is_fail(input logic [1:0] st);
    return st == ST_FAIL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_rise.sv
// ---------------------------------------------------------------------------
// edge_rise : one-cycle pulse on each rising edge of a level input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/window_watchdog.sv
// ---------------------------------------------------------------------------
// window_watchdog : windowed heartbeat supervisor driving a WDFAIL level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module window_watchdog
  import window_watchdog_pkg::*;
#(
  parameter int CNT_W = WD_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             KICK,
  input  logic [CNT_W-1:0] TIMEOUT,
  input  logic [CNT_W-1:0] WIN_OPEN,
  output logic             WDFAIL,
  output logic             EARLY,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] tmo_q;
  logic [CNT_W-1:0] win_q;
  logic             early_nxt;
  logic             load_cfg;
  logic             kev;
  logic [CNT_W-1:0] tmo_eff;
  logic             start_open;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;

  edge_rise u_kick_edge (
    .clk  (CLK),
    .rst  (RST),
    .d    (KICK),
    .rise (kev)
  );

  // Live config is only sampled here; it becomes effective when load_cfg fires.
  assign tmo_eff    = (TIMEOUT == '0) ? CNT_ONE : TIMEOUT;
  assign start_open = (WIN_OPEN == '0) || (WIN_OPEN >= tmo_eff);
  assign cnt_inc    = CNT + CNT_ONE;
  assign at_limit   = (CNT == (tmo_q - CNT_ONE));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT;
    early_nxt = EARLY;
    load_cfg  = 1'b0;

    if (!EN) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      early_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          load_cfg  = 1'b1;
          cnt_nxt   = '0;
          early_nxt = 1'b0;
          state_nxt = start_open ? ST_OPEN : ST_CLOSED;
        end
        ST_CLOSED: begin
          if (kev) begin
            state_nxt = ST_FAIL;
            early_nxt = 1'b1;
          end else if (at_limit) begin
            state_nxt = ST_FAIL;
            early_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == win_q) begin
              state_nxt = ST_OPEN;
            end
          end
        end
        ST_OPEN: begin
          if (kev) begin
            load_cfg  = 1'b1;
            cnt_nxt   = '0;
            early_nxt = 1'b0;
            state_nxt = start_open ? ST_OPEN : ST_CLOSED;
          end else if (at_limit) begin
            state_nxt = ST_FAIL;
            early_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_FAIL: begin
          // Count is frozen so downstream logic can see where the miss happened.
          if (kev) begin
            load_cfg  = 1'b1;
            cnt_nxt   = '0;
            early_nxt = 1'b0;
            state_nxt = start_open ? ST_OPEN : ST_CLOSED;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          early_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      CNT   <= '0;
      tmo_q <= CNT_ONE;
      win_q <= '0;
    end else begin
      state <= state_nxt;
      CNT   <= cnt_nxt;
      if (load_cfg) begin
        tmo_q <= tmo_eff;
        win_q <= WIN_OPEN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WDFAIL <= 1'b0;
      EARLY  <= 1'b0;
    end else begin
      WDFAIL <= is_fail(state_nxt);
      EARLY  <= early_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_watchdog.sv
// ---------------------------------------------------------------------------
// tb_window_watchdog : scenario bench for window_watchdog with a vector queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_window_watchdog;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        KICK;
  logic [15:0] TIMEOUT;
  logic [15:0] WIN_OPEN;
  logic        WDFAIL;
  logic        EARLY;
  logic [15:0] CNT;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        en;
    logic        kick;
    logic [15:0] tmo;
    logic [15:0] win;
    logic        fail;
    logic        early;
    logic [15:0] cnt;
  } vec_t;

  vec_t sb[$];

  window_watchdog #(.CNT_W(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .KICK     (KICK),
    .TIMEOUT  (TIMEOUT),
    .WIN_OPEN (WIN_OPEN),
    .WDFAIL   (WDFAIL),
    .EARLY    (EARLY),
    .CNT      (CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push(input logic en, input logic kick, input int tmo, input int win,
                      input logic f, input logic e, input int c);
    vec_t v;
    v.en = en; v.kick = kick; v.tmo = 16'(tmo); v.win = 16'(win);
    v.fail = f; v.early = e; v.cnt = 16'(c);
    sb.push_back(v);
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; KICK = 1'b0; TIMEOUT = 16'd0; WIN_OPEN = 16'd0;
    #3;
    tests++;
    if ({WDFAIL, EARLY, CNT} !== {1'b0, 1'b0, 16'd0}) begin
      failed++;
      $display("FAIL reset: fail=%b early=%b cnt=%0d, expected 0 0 0", WDFAIL, EARLY, CNT);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_timeout();
    int idx = 0;
    push(0, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 0);
    for (int j = 1; j <= 9; j++) push(1, 0, 10, 4, 0, 0, j);
    for (int j = 0; j < 3; j++) push(1, 0, 10, 4, 1, 0, 9);
    push(1, 1, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 1);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL timeout[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_kick_in_window();
    int idx = 0;
    int c = 0;
    push(0, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      logic k = (c == 6);
      c = k ? 0 : c + 1;
      push(1, k, 10, 4, 0, 0, c);
    end
    push(0, 0, 10, 4, 0, 0, 0);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL kick_window[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_early_kick();
    int idx = 0;
    push(0, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 1);
    push(1, 0, 10, 4, 0, 0, 2);
    push(1, 1, 10, 4, 1, 1, 2);
    push(1, 0, 10, 4, 1, 1, 2);
    push(1, 1, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 1);
    push(0, 0, 10, 4, 0, 0, 0);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL early_kick[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_held_kick();
    int idx = 0;
    push(0, 0, 5, 0, 0, 0, 0);
    push(1, 0, 5, 0, 0, 0, 0);
    push(1, 0, 5, 0, 0, 0, 1);
    push(1, 1, 5, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      if (i < 5) push(1, 1, 5, 0, 0, 0, i);
      else       push(1, 1, 5, 0, 1, 0, 4);
    end
    push(1, 0, 5, 0, 1, 0, 4);
    push(1, 1, 5, 0, 0, 0, 0);
    push(1, 0, 5, 0, 0, 0, 1);
    push(0, 0, 5, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL held_kick[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_timeout_zero();
    int idx = 0;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1, 0, 0);
    push(1, 1, 0, 0, 0, 0, 0);
    // TIMEOUT changes to 8 mid-run; the latched value of 1 still governs.
    push(1, 0, 8, 0, 1, 0, 0);
    push(1, 1, 8, 0, 0, 0, 0);
    for (int j = 1; j <= 7; j++) push(1, 0, 8, 0, 0, 0, j);
    push(1, 0, 8, 0, 1, 0, 7);
    push(0, 0, 8, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL timeout_zero[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_async_reset();
    int idx = 0;
    push(0, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 0);
    for (int j = 1; j <= 5; j++) push(1, 0, 10, 4, 0, 0, j);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL async_reset_pre[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
    RST = 1'b1;
    #2;
    tests++;
    if ({WDFAIL, EARLY, CNT} !== {1'b0, 1'b0, 16'd0}) begin
      failed++;
      $display("FAIL async_reset: fail=%b early=%b cnt=%0d, expected 0 0 0", WDFAIL, EARLY, CNT);
    end
    #2;
    RST = 1'b0;
    idx = 0;
    push(1, 0, 10, 4, 0, 0, 0);
    push(1, 0, 10, 4, 0, 0, 1);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL async_reset_post[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  task automatic test_en_fall();
    int idx = 0;
    push(0, 0, 2, 0, 0, 0, 0);
    push(1, 0, 2, 0, 0, 0, 0);
    push(1, 0, 2, 0, 0, 0, 1);
    push(1, 0, 2, 0, 1, 0, 1);
    push(0, 1, 2, 0, 0, 0, 0);
    push(1, 1, 2, 0, 0, 0, 0);
    push(1, 0, 2, 0, 0, 0, 1);
    push(0, 0, 2, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      vec_t v = sb.pop_front();
      EN = v.en; KICK = v.kick; TIMEOUT = v.tmo; WIN_OPEN = v.win;
      @(posedge CLK); #1;
      tests++;
      if ({WDFAIL, EARLY, CNT} !== {v.fail, v.early, v.cnt}) begin
        failed++;
        $display("FAIL en_fall[%0d]: fail=%b early=%b cnt=%0d, expected fail=%b early=%b cnt=%0d",
                 idx, WDFAIL, EARLY, CNT, v.fail, v.early, v.cnt);
      end
      idx++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_timeout();
    test_kick_in_window();
    test_early_kick();
    test_held_kick();
    test_timeout_zero();
    test_async_reset();
    test_en_fall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
